button_counter_display: RTL and testbench

- Board-side responder for the lab board signals: consumes the push_button_n and switch stimulus, drives seven_seg_n and led_green.
- Synchronises and debounces four active-low pushbuttons into one-cycle press pulses.
- Pulses operate an 8-digit BCD up/down counter, shown on the eight seven-segment displays.
- Sits at top level between board pins and user logic; also serves as the standard DUT for the board testbench.

---
 rtl/button_counter_display.sv | 192 +++++++++++++++++++
 tb/tb_button_counter_display.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_counter_display.sv
// Lab-board responder: debounced pushbuttons drive an 8-digit BCD up/down counter shown on seven-segment displays.
// Latency: button level to display is DEBOUNCE_CYCLES+5 edges; no backpressure, every accepted press is applied.

module button_counter_display_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock_50,
  input  logic reset,
  input  logic raw_n,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      count  <= '0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      if (sync2 == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= sync2;
        count  <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

module button_counter_display #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clock_50,
  input  logic            reset,
  input  logic [3:0]      push_button_n,
  input  logic [17:0]     switch,
  output logic [7:0][6:0] seven_seg_n,
  output logic [8:0]      led_green
);

  localparam logic [31:0] BCD_MAX = 32'h9999_9999;

  logic [3:0]      stable;
  logic [3:0]      stable_d;
  logic [3:0]      pulse;
  logic [31:0]     count_bcd;
  logic            wrap;
  logic [31:0]     load_val;
  logic [7:0][6:0] seg_next;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    button_counter_display_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock_50(clock_50),
      .reset   (reset),
      .raw_n   (push_button_n[b]),
      .stable  (stable[b])
    );
  end

  // Press pulse only on a stable high-to-low transition; releases are ignored.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      stable_d <= 4'hF;
      pulse    <= 4'h0;
    end else begin
      stable_d <= stable;
      pulse    <= stable_d & ~stable;
    end
  end

  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] bcd_dec(input logic [31:0] v);
    logic [31:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Load digits saturate at 9 so the counter never holds a non-BCD nibble.
  always_comb begin
    load_val = '0;
    for (int i = 0; i < 4; i++) begin
      load_val[i*4 +: 4] = (switch[i*4 +: 4] > 4'd9) ? 4'd9 : switch[i*4 +: 4];
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else if (pulse[3]) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else if (pulse[2]) begin
      count_bcd <= load_val;
    end else if (pulse[0] && pulse[1]) begin
      count_bcd <= count_bcd;
    end else if (pulse[0]) begin
      count_bcd <= bcd_inc(count_bcd);
      if (count_bcd == BCD_MAX) wrap <= 1'b1;
    end else if (pulse[1]) begin
      count_bcd <= bcd_dec(count_bcd);
      if (count_bcd == '0) wrap <= 1'b1;
    end
  end

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h40;
      4'd1:    seg_enc = 7'h79;
      4'd2:    seg_enc = 7'h24;
      4'd3:    seg_enc = 7'h30;
      4'd4:    seg_enc = 7'h19;
      4'd5:    seg_enc = 7'h12;
      4'd6:    seg_enc = 7'h02;
      4'd7:    seg_enc = 7'h78;
      4'd8:    seg_enc = 7'h00;
      4'd9:    seg_enc = 7'h10;
      default: seg_enc = 7'h7F;
    endcase
  endfunction

  // Scan from the top digit; 'leading' stays set until the first nonzero digit.
  always_comb begin
    logic leading;
    seg_next = '1;
    leading  = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (count_bcd[i*4 +: 4] != 4'd0) leading = 1'b0;
      if (switch[17]) begin
        seg_next[i] = 7'h7F;
      end else if (switch[16] && leading && (i != 0)) begin
        seg_next[i] = 7'h7F;
      end else begin
        seg_next[i] = seg_enc(count_bcd[i*4 +: 4]);
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      seven_seg_n <= {8{7'h7F}};
      led_green   <= '0;
    end else begin
      seven_seg_n <= seg_next;
      led_green   <= {wrap, count_bcd[3:0], ~stable};
    end
  end

endmodule

// File: tb/tb_button_counter_display.sv
// Bench for button_counter_display with DEBOUNCE_CYCLES=4; expected displays are queued at each press
// and popped when the DUT's fixed press-to-display latency has elapsed.

module tb_button_counter_display;

  localparam int DB = 4;
  localparam int LAT_DISP = DB + 5;

  logic            clock_50;
  logic            reset;
  logic [3:0]      push_button_n;
  logic [17:0]     switch;
  logic [7:0][6:0] seven_seg_n;
  logic [8:0]      led_green;

  typedef struct packed {
    logic [7:0][6:0] seg;
    logic [4:0]      led_hi;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  button_counter_display #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock_50     (clock_50),
    .reset        (reset),
    .push_button_n(push_button_n),
    .switch       (switch),
    .seven_seg_n  (seven_seg_n),
    .led_green    (led_green)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h40; 4'd1: enc = 7'h79; 4'd2: enc = 7'h24; 4'd3: enc = 7'h30;
      4'd4: enc = 7'h19; 4'd5: enc = 7'h12; 4'd6: enc = 7'h02; 4'd7: enc = 7'h78;
      4'd8: enc = 7'h00; 4'd9: enc = 7'h10; default: enc = 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0][6:0] disp(input logic [31:0] bcd, input logic sup, input logic blank);
    logic [7:0][6:0] r;
    bit seen;
    seen = 0;
    for (int i = 7; i >= 0; i--) begin
      if (bcd[i*4 +: 4] != 4'd0) seen = 1;
      if (blank) r[i] = 7'h7F;
      else if (sup && !seen && i != 0) r[i] = 7'h7F;
      else r[i] = enc(bcd[i*4 +: 4]);
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  // Press the masked buttons, hold until the display should have updated, compare, then release and settle.
  task automatic press(input logic [3:0] mask, input logic [31:0] exp_bcd, input logic exp_wrap,
                       input string name);
    exp_t e;
    push_button_n = ~mask;
    e.seg    = disp(exp_bcd, switch[16], switch[17]);
    e.led_hi = {exp_wrap, exp_bcd[3:0]};
    exp_q.push_back(e);
    tick(LAT_DISP);
    e = exp_q.pop_front();
    vectors++;
    if (seven_seg_n !== e.seg) begin
      miscompares++;
      $display("FAIL %s seg: got %h want %h", name, seven_seg_n, e.seg);
    end
    vectors++;
    if (led_green[8:4] !== e.led_hi) begin
      miscompares++;
      $display("FAIL %s led[8:4]: got %h want %h", name, led_green[8:4], e.led_hi);
    end
    push_button_n = 4'hF;
    tick(DB + 4);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    push_button_n = 4'hF;
    switch = '0;
    tick(3);
    vectors++;
    if (seven_seg_n !== {8{7'h7F}}) begin
      miscompares++;
      $display("FAIL reset_seg: got %h want all 7F", seven_seg_n);
    end
    vectors++;
    if (led_green !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_led: got %h want 000", led_green);
    end
    reset = 1'b0;
    tick(1);
    vectors++;
    if (seven_seg_n !== disp(32'h0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL post_reset_seg: got %h want all 40", seven_seg_n);
    end
  endtask

  task automatic test_glitch;
    for (int k = 0; k < 5; k++) begin
      push_button_n = 4'hE;
      tick(3);
      push_button_n = 4'hF;
      tick(3);
      vectors++;
      if (led_green[3:0] !== 4'h0) begin
        miscompares++;
        $display("FAIL glitch_led%0d: got %h want 0", k, led_green[3:0]);
      end
    end
    tick(DB + 4);
    vectors++;
    if (seven_seg_n !== disp(32'h0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL glitch_seg: got %h want all 40", seven_seg_n);
    end
  endtask

  task automatic test_single_press;
    exp_t e;
    push_button_n = 4'hE;
    e.seg    = disp(32'h1, 1'b0, 1'b0);
    e.led_hi = 5'h01;
    exp_q.push_back(e);
    tick(6);
    vectors++;
    if (led_green[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL led0_edge6: got %b want 0", led_green[0]);
    end
    tick(1);
    vectors++;
    if (led_green[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL led0_edge7: got %b want 1", led_green[0]);
    end
    tick(1);
    vectors++;
    if (seven_seg_n !== disp(32'h0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL seg_edge8_early: got %h want all 40", seven_seg_n);
    end
    tick(1);
    e = exp_q.pop_front();
    vectors++;
    if (seven_seg_n !== e.seg) begin
      miscompares++;
      $display("FAIL seg_edge9: got %h want %h", seven_seg_n, e.seg);
    end
    vectors++;
    if (led_green[8:4] !== e.led_hi) begin
      miscompares++;
      $display("FAIL led_hi_edge9: got %h want %h", led_green[8:4], e.led_hi);
    end
    tick(1);
    push_button_n = 4'hF;
    tick(10);
    vectors++;
    if (seven_seg_n !== disp(32'h1, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL held_once: got %h want %h", seven_seg_n, disp(32'h1, 1'b0, 1'b0));
    end
    vectors++;
    if (led_green[3:0] !== 4'h0) begin
      miscompares++;
      $display("FAIL released_led: got %h want 0", led_green[3:0]);
    end
  endtask

  task automatic test_wrap_clear;
    press(4'b1000, 32'h0, 1'b0, "clear_pre");
    press(4'b0010, 32'h9999_9999, 1'b1, "dec_wrap");
    press(4'b1000, 32'h0, 1'b0, "clear_wrap");
  endtask

  task automatic test_load_display;
    switch = {2'b01, 16'h12F4};
    press(4'b0100, 32'h0000_1294, 1'b0, "load_sat");
    switch[17] = 1'b1;
    tick(1);
    vectors++;
    if (seven_seg_n !== {8{7'h7F}}) begin
      miscompares++;
      $display("FAIL blank: got %h want all 7F", seven_seg_n);
    end
    switch[17] = 1'b0;
    tick(1);
    vectors++;
    if (seven_seg_n !== disp(32'h0000_1294, 1'b1, 1'b0)) begin
      miscompares++;
      $display("FAIL unblank: got %h want %h", seven_seg_n, disp(32'h0000_1294, 1'b1, 1'b0));
    end
  endtask

  task automatic test_back_to_back;
    switch = 18'h0_0009;
    press(4'b0100, 32'h9, 1'b0, "load9");
    press(4'b0011, 32'h9, 1'b0, "inc_dec_hold");
    press(4'b0001, 32'h10, 1'b0, "bcd_carry");
  endtask

  task automatic test_reset_mid_debounce;
    switch = '0;
    push_button_n = 4'hE;
    tick(4);
    reset = 1'b1;
    push_button_n = 4'hF;
    tick(1);
    vectors++;
    if (seven_seg_n !== {8{7'h7F}}) begin
      miscompares++;
      $display("FAIL midreset_seg: got %h want all 7F", seven_seg_n);
    end
    reset = 1'b0;
    tick(1);
    vectors++;
    if (seven_seg_n !== disp(32'h0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL midreset_after: got %h want all 40", seven_seg_n);
    end
    tick(12);
    vectors++;
    if (seven_seg_n !== disp(32'h0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL midreset_nopulse: got %h want all 40", seven_seg_n);
    end
    vectors++;
    if (led_green !== 9'h000) begin
      miscompares++;
      $display("FAIL midreset_led: got %h want 000", led_green);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    push_button_n = 4'hF;
    switch = '0;
    test_reset;
    test_glitch;
    test_single_press;
    test_wrap_clear;
    test_load_display;
    test_back_to_back;
    test_reset_mid_debounce;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
